// File: rtl/msi_cache_ctrl.sv
// Direct-mapped write-back L1 cache controller with MSI line state, a held-request
// snooping bus port and registered snoop responses.
module msi_cache_ctrl #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned SETS       = 4,
  parameter int unsigned LINE_BYTES = 4,
  localparam int unsigned OFF_W  = $clog2(LINE_BYTES),
  localparam int unsigned IDX_W  = $clog2(SETS),
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W,
  localparam int unsigned LINE_W = 8 * LINE_BYTES,
  localparam int unsigned BA_W   = ADDR_W - OFF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_valid,
  input  logic              p_write,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [7:0]        p_wdata,
  output logic              p_ready,
  output logic [7:0]        p_rdata,
  output logic              b_req,
  output logic [1:0]        b_cmd,
  output logic [BA_W-1:0]   b_addr,
  output logic [LINE_W-1:0] b_wdata,
  input  logic              b_gnt,
  input  logic [LINE_W-1:0] b_rdata,
  input  logic              snp_valid,
  input  logic [1:0]        snp_cmd,
  input  logic [BA_W-1:0]   snp_addr,
  output logic              snp_hit,
  output logic              snp_dirty,
  output logic [LINE_W-1:0] snp_data,
  output logic [1:0]        stat
);

  typedef enum logic [2:0] {IDLE, WB, GAP, FILL, UPGR, RESP} state_e;
  typedef enum logic [1:0] {LS_I = 2'b00, LS_S = 2'b10, LS_M = 2'b11} line_st_e;
  typedef enum logic [1:0] {CMD_GETS = 2'b00, CMD_GETM = 2'b01,
                            CMD_INV  = 2'b10, CMD_PUTM = 2'b11} bus_cmd_e;

  state_e            st_q, st_d;
  logic [LINE_W-1:0] data_q [SETS];
  logic [LINE_W-1:0] data_d [SETS];
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [TAG_W-1:0]  tag_d  [SETS];
  line_st_e          lst_q  [SETS];
  line_st_e          lst_d  [SETS];
  logic              snp_hit_q, snp_hit_d;
  logic              snp_dirty_q, snp_dirty_d;
  logic [LINE_W-1:0] snp_data_q, snp_data_d;

  logic [OFF_W-1:0]  p_off;
  logic [IDX_W-1:0]  p_idx, s_idx;
  logic [TAG_W-1:0]  p_tag, s_tag;
  line_st_e          cur_st;
  logic              p_hit, s_hit, s_kills_target;
  logic [LINE_W-1:0] rd_line;

  function automatic logic [LINE_W-1:0] merge_byte(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  off,
                                                   input logic [7:0]        wb);
    logic [LINE_W-1:0] mask;
    mask = {{(LINE_W-8){1'b0}}, 8'hFF} << {off, 3'b000};
    return (line & ~mask) | ({{(LINE_W-8){1'b0}}, wb} << {off, 3'b000});
  endfunction

  assign p_off  = p_addr[OFF_W-1:0];
  assign p_idx  = p_addr[OFF_W +: IDX_W];
  assign p_tag  = p_addr[ADDR_W-1 -: TAG_W];
  assign s_idx  = snp_addr[IDX_W-1:0];
  assign s_tag  = snp_addr[BA_W-1 -: TAG_W];
  assign cur_st = lst_q[p_idx];
  assign p_hit  = (tag_q[p_idx] == p_tag) && (cur_st != LS_I);
  assign s_hit  = snp_valid && (tag_q[s_idx] == s_tag) && (lst_q[s_idx] != LS_I);
  assign s_kills_target = s_hit && (snp_cmd == CMD_GETM || snp_cmd == CMD_INV)
                          && (snp_addr == p_addr[ADDR_W-1:OFF_W]);
  assign stat      = lst_q[p_idx];
  assign snp_hit   = snp_hit_q;
  assign snp_dirty = snp_dirty_q;
  assign snp_data  = snp_data_q;

  always_comb begin
    st_d        = st_q;
    data_d      = data_q;
    tag_d       = tag_q;
    lst_d       = lst_q;
    snp_hit_d   = s_hit;
    snp_dirty_d = s_hit && (lst_q[s_idx] == LS_M);
    snp_data_d  = s_hit ? data_q[s_idx] : '0;
    p_ready     = 1'b0;
    p_rdata     = '0;
    b_req       = 1'b0;
    b_cmd       = '0;
    b_addr      = '0;
    b_wdata     = '0;
    rd_line     = data_q[p_idx] >> {p_off, 3'b000};

    // Snoop update is applied first; processor-side updates below overwrite it.
    if (s_hit) begin
      if (snp_cmd == CMD_GETS) begin
        if (lst_q[s_idx] == LS_M) lst_d[s_idx] = LS_S;
      end else if (snp_cmd != 2'b11) begin
        lst_d[s_idx] = LS_I;
      end
    end

    case (st_q)
      IDLE: begin
        // A same-index snoop defers the lookup so it sees the post-snoop state.
        if (p_valid && !(snp_valid && s_idx == p_idx)) begin
          if (p_hit && !p_write) begin
            st_d = RESP;
          end else if (p_hit && cur_st == LS_M) begin
            data_d[p_idx] = merge_byte(data_q[p_idx], p_off, p_wdata);
            st_d = RESP;
          end else if (p_hit) begin
            st_d = UPGR;
          end else if (cur_st == LS_M) begin
            st_d = WB;
          end else begin
            st_d = FILL;
          end
        end
      end
      WB: begin
        b_req   = 1'b1;
        b_cmd   = CMD_PUTM;
        b_addr  = {tag_q[p_idx], p_idx};
        b_wdata = data_q[p_idx];
        if (b_gnt) begin
          lst_d[p_idx] = LS_I;
          st_d = GAP;
        end
      end
      GAP: st_d = FILL;
      FILL: begin
        b_req  = 1'b1;
        b_cmd  = p_write ? CMD_GETM : CMD_GETS;
        b_addr = p_addr[ADDR_W-1:OFF_W];
        if (b_gnt) begin
          tag_d[p_idx]  = p_tag;
          data_d[p_idx] = p_write ? merge_byte(b_rdata, p_off, p_wdata) : b_rdata;
          lst_d[p_idx]  = p_write ? LS_M : LS_S;
          st_d = RESP;
        end
      end
      UPGR: begin
        b_req  = 1'b1;
        b_cmd  = CMD_INV;
        b_addr = p_addr[ADDR_W-1:OFF_W];
        if (b_gnt) begin
          // Lost the line to a snoop while waiting: refetch it with GetM.
          if (p_hit && cur_st == LS_S && !s_kills_target) begin
            lst_d[p_idx]  = LS_M;
            data_d[p_idx] = merge_byte(data_q[p_idx], p_off, p_wdata);
            st_d = RESP;
          end else begin
            st_d = GAP;
          end
        end
      end
      RESP: begin
        p_ready = 1'b1;
        p_rdata = rd_line[7:0];
        st_d    = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= IDLE;
      snp_hit_q   <= 1'b0;
      snp_dirty_q <= 1'b0;
      snp_data_q  <= '0;
      for (int unsigned i = 0; i < SETS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
        lst_q[i]  <= LS_I;
      end
    end else begin
      st_q        <= st_d;
      snp_hit_q   <= snp_hit_d;
      snp_dirty_q <= snp_dirty_d;
      snp_data_q  <= snp_data_d;
      data_q      <= data_d;
      tag_q       <= tag_d;
      lst_q       <= lst_d;
    end
  end

endmodule
